lc3_mem_ctrl: RTL and testbench
===============================

Name: lc3_mem_ctrl

Overview:
- Memory access stage between the LC-3 internal bus and datapath control FSM on one side, and the single-port 16x64K RAM on the other.
- Owns MAR and MDR.
- Converts the control FSM's MIO_EN/R_W request into RAM chip-select/write-enable sequencing.
- Returns a one-cycle R (memory-ready) pulse to the control FSM. A read-timeout counter flags a memory that never answers.

Parameters:
- TIMEOUT, 15: maximum RD_WAIT cycles before abort (1..255).
- ERR_DATA, 16'h0000: value loaded into MDR on a timed-out read.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- BUS  input  16  internal datapath bus value.
- LD_MAR  input  1  load MAR from BUS (IDLE only).
- LD_MDR  input  1  load MDR from BUS when MIO_EN=0 (IDLE only).
- MIO_EN  input  1  request memory access.
- R_W  input  1  access type: 1=write, 0=read; sampled with MIO_EN in IDLE.
- MAR  output  16  memory address register.
- MDR  output  16  memory data register (drives bus via external tristate).
- R  output  1  access complete, one-cycle pulse.
- ERR  output  1  sticky read-timeout flag.
- MEM_ADDR  output  16  RAM address (=MAR).
- MEM_DIN  output  16  RAM write data (=MDR).
- MEM_CS  output  1  RAM chip select.
- MEM_WE  output  1  RAM write enable.
- MEM_DOUT  input  16  RAM read data.
- MEM_READY  input  1  RAM read-data-valid.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE; MAR=MDR=0; R=ERR=MEM_CS=MEM_WE=0; wait counter=0. Reset mid-access aborts the access with no R pulse.
- MEM_ADDR and MEM_DIN are continuous copies of MAR and MDR. MAR and MDR do not change while the state is not IDLE.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, DONE.
- IDLE:
  - LD_MAR=1 -> MAR<=BUS.
  - LD_MDR=1 and MIO_EN=0 -> MDR<=BUS.
  - MIO_EN=1 and R_W=0 -> RD_ISSUE.
  - MIO_EN=1 and R_W=1 -> WR_ISSUE.
  - LD_MAR and MIO_EN in the same cycle: MAR loads first; the access uses the new MAR from RD_ISSUE/WR_ISSUE onward.
- RD_ISSUE: MEM_CS=1, MEM_WE=0 for exactly one cycle; counter cleared; -> RD_WAIT.
- RD_WAIT:
  - MEM_CS=0; counter increments each cycle.
  - MEM_READY=1 -> MDR<=MEM_DOUT, -> DONE.
  - Otherwise, counter==TIMEOUT -> MDR<=ERR_DATA, ERR<=1, -> DONE.
  - MEM_READY is only sampled in this state; its level in other states is ignored.
  - MEM_READY=1 on the same cycle the counter reaches TIMEOUT: ready wins, ERR unchanged.
- WR_ISSUE: MEM_CS=1, MEM_WE=1 for exactly one cycle (RAM captures MDR at MAR on this edge); -> DONE.
- DONE: R=1 for exactly this cycle; -> IDLE unconditionally.
- The control FSM drops MIO_EN in the cycle after R. If MIO_EN is still high in IDLE, a new back-to-back access starts.
- Latency, MIO_EN rise to R:
  - Write: 2 cycles.
  - Read: 3 cycles with a 1-cycle RAM.
  - Read timeout: TIMEOUT+2 cycles.
- ERR clears only on reset.
- LD_MAR/LD_MDR outside IDLE are ignored.
- Outputs are registered from state (Moore); no combinational path from inputs to MEM_CS/MEM_WE/R.

Decomposition:
- Shared package lc3_pkg:
  - State enum mem_state_t.
  - Constants for the R_W encoding (RW_READ=0, RW_WRITE=1).
  - WORD_W=16.
- One sub-module: the existing registerFF is instantiated twice for MAR and MDR, with an input mux and qualified LD. The FSM and counter stay in lc3_mem_ctrl.

Test Plan:
- Reset: assert RST_N=0 mid-RD_WAIT -> MAR=MDR=0, R=0, MEM_CS=0 immediately, no R pulse after release.
- Write: BUS=16'h3000 with LD_MAR; then BUS=16'hBEEF with LD_MDR; then MIO_EN=1, R_W=1 -> MEM_CS=MEM_WE=1 for one cycle with MEM_ADDR=16'h3000, MEM_DIN=16'hBEEF; R pulses 2 cycles after MIO_EN.
- Read with RAM model: MAR=16'h3000 -> MEM_CS=1, MEM_WE=0 one cycle; MDR=16'hBEEF; R pulses exactly once, 3 cycles after MIO_EN.
- Timeout: MEM_READY tied 0, TIMEOUT=15 -> R at cycle 17, MDR=ERR_DATA, ERR=1 and stays 1 through a following good read.
- Back-to-back: MIO_EN held high across R -> second read issues in the cycle after DONE; LD_MAR/LD_MDR pulses during RD_WAIT leave MAR/MDR unchanged.
- Simultaneous: LD_MAR (BUS=16'h0042) and MIO_EN in the same IDLE cycle -> MEM_ADDR=16'h0042 during RD_ISSUE; MEM_READY coincident with counter==TIMEOUT -> ERR stays 0, MDR=MEM_DOUT.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 memory access stage.
package lc3_pkg;

    localparam int unsigned WORD_W = 16;

    // Encoding of the R_W access-type strobe.
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR_ISSUE = 3'd3,
        ST_DONE     = 3'd4
    } mem_state_t;

endpackage

// File: rtl/registerFF.sv
// Loadable register with asynchronous active-low clear.
module registerFF
    import lc3_pkg::*;
#(
    parameter int unsigned W = WORD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Hold unless ld is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory access stage: owns MAR/MDR and sequences the single-port RAM.
module lc3_mem_ctrl
    import lc3_pkg::*;
#(
    parameter int unsigned        TIMEOUT  = 15,
    parameter logic [WORD_W-1:0]  ERR_DATA = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] bus,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic              mio_en,
    input  logic              r_w,
    output logic [WORD_W-1:0] mar,
    output logic [WORD_W-1:0] mdr,
    output logic              r,
    output logic              err,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_din,
    output logic              mem_cs,
    output logic              mem_we,
    input  logic [WORD_W-1:0] mem_dout,
    input  logic              mem_ready
);

    localparam int unsigned CNT_W = 8;

    mem_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic              timeout_c;
    logic              mar_ld_c;
    logic              mdr_ld_c;
    logic [WORD_W-1:0] mdr_d_c;

    // The wait counter holds the number of RD_WAIT cycles already spent.
    assign timeout_c = (cnt == CNT_W'(TIMEOUT - 1));

    // MAR only loads from the bus while idle.
    assign mar_ld_c = (state == ST_IDLE) && ld_mar;

    // MDR source select: bus in IDLE, RAM data or error word at the end of a read.
    always_comb begin
        mdr_ld_c = 1'b0;
        mdr_d_c  = bus;
        if ((state == ST_IDLE) && ld_mdr && !mio_en) begin
            mdr_ld_c = 1'b1;
            mdr_d_c  = bus;
        end else if (state == ST_RD_WAIT) begin
            if (mem_ready) begin
                mdr_ld_c = 1'b1;
                mdr_d_c  = mem_dout;
            end else if (timeout_c) begin
                mdr_ld_c = 1'b1;
                mdr_d_c  = ERR_DATA;
            end
        end
    end

    registerFF #(.W(WORD_W)) u_mar (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (mar_ld_c),
        .d     (bus),
        .q     (mar)
    );

    registerFF #(.W(WORD_W)) u_mdr (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (mdr_ld_c),
        .d     (mdr_d_c),
        .q     (mdr)
    );

    assign mem_addr = mar;
    assign mem_din  = mdr;

    // Access sequencer; strobes are set on entry to the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            r      <= 1'b0;
            err    <= 1'b0;
            mem_cs <= 1'b0;
            mem_we <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mio_en) begin
                        mem_cs <= 1'b1;
                        if (r_w == RW_WRITE) begin
                            state  <= ST_WR_ISSUE;
                            mem_we <= 1'b1;
                        end else begin
                            state  <= ST_RD_ISSUE;
                            mem_we <= 1'b0;
                        end
                    end
                end
                ST_RD_ISSUE: begin
                    state  <= ST_RD_WAIT;
                    cnt    <= '0;
                    mem_cs <= 1'b0;
                    mem_we <= 1'b0;
                end
                ST_RD_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mem_ready) begin
                        state <= ST_DONE;
                        r     <= 1'b1;
                    end else if (timeout_c) begin
                        state <= ST_DONE;
                        r     <= 1'b1;
                        err   <= 1'b1;
                    end
                end
                ST_WR_ISSUE: begin
                    state  <= ST_DONE;
                    mem_cs <= 1'b0;
                    mem_we <= 1'b0;
                    r      <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    r     <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    r      <= 1'b0;
                    mem_cs <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl with a 1-cycle RAM model and a scripted RAM.
module tb_lc3_mem_ctrl;

    localparam int unsigned TO   = 15;
    localparam logic [15:0] ERRD = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bus = '0;
    logic        ld_mar = 1'b0, ld_mdr = 1'b0, mio_en = 1'b0, r_w = 1'b0;
    logic [15:0] mar, mdr, mem_addr, mem_din, mem_dout;
    logic        r, err, mem_cs, mem_we, mem_ready;

    // RAM model (ram_mode=1) or scripted ready/data (ram_mode=0)
    logic        ram_mode = 1'b0, man_ready = 1'b0;
    logic [15:0] man_dout = '0;
    logic [15:0] ram [0:65535];
    logic [15:0] ram_q = '0;
    logic        ram_valid = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [15:0] sb [logic [15:0]];
    logic [15:0] wq [$];
    logic        exp_err = 1'b0;

    lc3_mem_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ld_mar    (ld_mar),
        .ld_mdr    (ld_mdr),
        .mio_en    (mio_en),
        .r_w       (r_w),
        .mar       (mar),
        .mdr       (mdr),
        .r         (r),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_dout  (mem_dout),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    assign mem_ready = ram_mode ? ram_valid : man_ready;
    assign mem_dout  = ram_mode ? ram_q : man_dout;

    always @(posedge clk) begin
        ram_valid <= 1'b0;
        if (mem_cs && mem_we) begin
            ram[mem_addr] <= mem_din;
        end else if (mem_cs) begin
            ram_q     <= ram[mem_addr];
            ram_valid <= 1'b1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_regs(input logic [15:0] a, input logic [15:0] d);
        bus = a; ld_mar = 1'b1;
        tick();
        ld_mar = 1'b0; bus = d; ld_mdr = 1'b1;
        tick();
        ld_mdr = 1'b0;
    endtask

    // One access from MIO_EN rise; cycle n counts edges after the rise.
    task automatic run_access(input logic rw, input logic poke, input int ready_at,
                              input logic [15:0] rd_val, input logic noise,
                              output int lat, output int cs_n, output int we_n,
                              output int r_n, output logic [15:0] cs_addr,
                              output logic [15:0] cs_din);
        lat = -1; cs_n = 0; we_n = 0; r_n = 0; cs_addr = '0; cs_din = '0;
        mio_en = 1'b1; r_w = rw;
        for (int n = 1; n <= int'(TO) + 8; n++) begin
            tick();
            ld_mar = 1'b0; ld_mdr = 1'b0;
            man_ready = (n == ready_at) || (noise && n == 1);
            man_dout  = (n == ready_at) ? rd_val : ~rd_val;
            if (mem_cs) begin cs_n++; cs_addr = mem_addr; cs_din = mem_din; end
            if (mem_we) we_n++;
            if (r) begin
                r_n++;
                if (lat < 0) lat = n;
                mio_en = 1'b0;
            end else if (poke && lat < 0) begin
                ld_mar = 1'b1; ld_mdr = 1'b1; bus = 16'($urandom);
            end
            if (lat >= 0 && n >= lat + 2) break;
        end
        mio_en = 1'b0; ld_mar = 1'b0; ld_mdr = 1'b0; man_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({mar, mdr, r, err, mem_cs, mem_we} !== 36'h0) begin
            errors++; $display("FAIL reset_state got=%h exp=0", {mar, mdr, r, err, mem_cs, mem_we});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({mar, mdr, r, err, mem_cs, mem_we} !== 36'h0) begin
            errors++; $display("FAIL reset_release got=%h exp=0", {mar, mdr, r, err, mem_cs, mem_we});
        end
    endtask

    task automatic test_write;
        int lat, cs_n, we_n, r_n; logic [15:0] ca, cd;
        load_regs(16'h3000, 16'hBEEF);
        run_access(1'b1, 1'b0, 0, 16'h0, 1'b0, lat, cs_n, we_n, r_n, ca, cd);
        sb[16'h3000] = 16'hBEEF; wq.push_back(16'h3000);
        checks++; if (lat !== 2) begin errors++; $display("FAIL write_lat got=%0d exp=2", lat); end
        checks++; if (cs_n !== 1) begin errors++; $display("FAIL write_cs_cycles got=%0d exp=1", cs_n); end
        checks++; if (we_n !== 1) begin errors++; $display("FAIL write_we_cycles got=%0d exp=1", we_n); end
        checks++; if (ca !== 16'h3000) begin errors++; $display("FAIL write_addr got=%h exp=3000", ca); end
        checks++; if (cd !== 16'hBEEF) begin errors++; $display("FAIL write_din got=%h exp=beef", cd); end
        checks++; if (r_n !== 1) begin errors++; $display("FAIL write_r_pulses got=%0d exp=1", r_n); end
    endtask

    task automatic test_read;
        int lat, cs_n, we_n, r_n; logic [15:0] ca, cd;
        bus = 16'h0000; ld_mdr = 1'b1; tick(); ld_mdr = 1'b0;
        ram_mode = 1'b1;
        run_access(1'b0, 1'b0, 0, 16'h0, 1'b0, lat, cs_n, we_n, r_n, ca, cd);
        checks++; if (lat !== 3) begin errors++; $display("FAIL read_lat got=%0d exp=3", lat); end
        checks++; if (cs_n !== 1 || we_n !== 0) begin errors++; $display("FAIL read_strobes got=%0d/%0d exp=1/0", cs_n, we_n); end
        checks++; if (ca !== 16'h3000) begin errors++; $display("FAIL read_addr got=%h exp=3000", ca); end
        checks++; if (mdr !== 16'hBEEF) begin errors++; $display("FAIL read_mdr got=%h exp=beef", mdr); end
        checks++; if (r_n !== 1) begin errors++; $display("FAIL read_r_pulses got=%0d exp=1", r_n); end
    endtask

    task automatic test_simultaneous;
        int lat, cs_n, we_n, r_n; logic [15:0] ca, cd, dv;
        ram_mode = 1'b0;
        dv = 16'($urandom) | 16'h0100;
        bus = 16'h0042; ld_mar = 1'b1;
        run_access(1'b0, 1'b0, int'(TO) + 1, dv, 1'b0, lat, cs_n, we_n, r_n, ca, cd);
        checks++; if (ca !== 16'h0042) begin errors++; $display("FAIL simul_addr got=%h exp=0042", ca); end
        checks++; if (lat !== int'(TO) + 2) begin errors++; $display("FAIL simul_lat got=%0d exp=%0d", lat, TO + 2); end
        checks++; if (mdr !== dv) begin errors++; $display("FAIL simul_mdr got=%h exp=%h", mdr, dv); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL simul_err got=%b exp=0", err); end
    endtask

    task automatic test_back_to_back;
        int rc[$]; int cc[$]; logic prev_cs;
        load_regs(16'h3000, 16'h0000);
        ram_mode = 1'b1; prev_cs = 1'b0;
        mio_en = 1'b1; r_w = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            ld_mar = 1'b0; ld_mdr = 1'b0;
            if (r) begin rc.push_back(n); if (rc.size() == 2) mio_en = 1'b0; end
            if (mem_cs) cc.push_back(n);
            if (mem_cs || prev_cs) begin ld_mar = 1'b1; ld_mdr = 1'b1; bus = 16'($urandom); end
            prev_cs = mem_cs;
        end
        mio_en = 1'b0; ld_mar = 1'b0; ld_mdr = 1'b0;
        checks++; if (rc.size() !== 2) begin errors++; $display("FAIL b2b_r_count got=%0d exp=2", rc.size()); end
        else begin
            checks++; if (rc[0] !== 3 || rc[1] !== 7) begin errors++; $display("FAIL b2b_r_cycles got=%0d,%0d exp=3,7", rc[0], rc[1]); end
        end
        checks++; if (cc.size() !== 2 || cc[0] !== 1 || cc[1] !== 5) begin errors++; $display("FAIL b2b_cs_cycles got_count=%0d exp=2 at 1,5", cc.size()); end
        checks++; if (mar !== 16'h3000) begin errors++; $display("FAIL b2b_mar got=%h exp=3000", mar); end
        checks++; if (mdr !== 16'hBEEF) begin errors++; $display("FAIL b2b_mdr got=%h exp=beef", mdr); end
    endtask

    task automatic test_random;
        int lat, cs_n, we_n, r_n, op, ra, elat; logic [15:0] ca, cd, a, d, emdr;
        for (int it = 0; it < 24; it++) begin
            op = (wq.size() == 0) ? 0 : int'($urandom_range(2, 0));
            if (op == 0) begin
                a = 16'($urandom); d = 16'($urandom);
                load_regs(a, d);
                ram_mode = 1'b1;
                if ($urandom_range(1, 0) == 1) begin bus = ~d; ld_mdr = 1'b1; end
                run_access(1'b1, 1'b1, 0, 16'h0, 1'b0, lat, cs_n, we_n, r_n, ca, cd);
                if (!sb.exists(a)) wq.push_back(a);
                sb[a] = d;
                checks++; if (lat !== 2 || we_n !== 1) begin errors++; $display("FAIL rnd_write_seq it=%0d lat=%0d we=%0d exp=2/1", it, lat, we_n); end
                checks++; if (ca !== a || cd !== d) begin errors++; $display("FAIL rnd_write_bus it=%0d got=%h/%h exp=%h/%h", it, ca, cd, a, d); end
                checks++; if (mar !== a || mdr !== d) begin errors++; $display("FAIL rnd_write_regs it=%0d got=%h/%h exp=%h/%h", it, mar, mdr, a, d); end
            end else if (op == 1) begin
                a = 16'($urandom); d = 16'($urandom);
                ra = int'($urandom_range(int'(TO) + 4, 2));
                ram_mode = 1'b0;
                bus = a; ld_mar = 1'b1;
                run_access(1'b0, 1'b1, ra, d, 1'b1, lat, cs_n, we_n, r_n, ca, cd);
                if (ra <= int'(TO) + 1) begin elat = ra + 1; emdr = d; end
                else begin elat = int'(TO) + 2; emdr = ERRD; exp_err = 1'b1; end
                checks++; if (lat !== elat) begin errors++; $display("FAIL rnd_read_lat it=%0d got=%0d exp=%0d", it, lat, elat); end
                checks++; if (mdr !== emdr) begin errors++; $display("FAIL rnd_read_mdr it=%0d got=%h exp=%h", it, mdr, emdr); end
                checks++; if (err !== exp_err || mar !== a || ca !== a) begin errors++; $display("FAIL rnd_read_state it=%0d err=%b mar=%h exp=%b/%h", it, err, mar, exp_err, a); end
            end else begin
                a = wq[$urandom_range(wq.size() - 1, 0)];
                load_regs(a, ~sb[a]);
                ram_mode = 1'b1;
                run_access(1'b0, 1'b0, 0, 16'h0, 1'b0, lat, cs_n, we_n, r_n, ca, cd);
                checks++; if (lat !== 3 || mdr !== sb[a]) begin errors++; $display("FAIL rnd_readback it=%0d lat=%0d mdr=%h exp=3/%h", it, lat, mdr, sb[a]); end
            end
        end
    endtask

    task automatic test_timeout;
        int lat, cs_n, we_n, r_n; logic [15:0] ca, cd;
        load_regs(16'h3000, 16'hBEEF);
        ram_mode = 1'b1;
        run_access(1'b1, 1'b0, 0, 16'h0, 1'b0, lat, cs_n, we_n, r_n, ca, cd);
        bus = 16'h1234; ld_mdr = 1'b1; tick(); ld_mdr = 1'b0;
        ram_mode = 1'b0;
        run_access(1'b0, 1'b0, 0, 16'h0, 1'b0, lat, cs_n, we_n, r_n, ca, cd);
        checks++; if (lat !== int'(TO) + 2) begin errors++; $display("FAIL timeout_lat got=%0d exp=%0d", lat, TO + 2); end
        checks++; if (mdr !== ERRD) begin errors++; $display("FAIL timeout_mdr got=%h exp=%h", mdr, ERRD); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err got=%b exp=1", err); end
        ram_mode = 1'b1;
        run_access(1'b0, 1'b0, 0, 16'h0, 1'b0, lat, cs_n, we_n, r_n, ca, cd);
        checks++; if (lat !== 3 || mdr !== 16'hBEEF) begin errors++; $display("FAIL after_timeout_read lat=%0d mdr=%h exp=3/beef", lat, mdr); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
    endtask

    task automatic test_reset_mid;
        int r_n, cs_n;
        load_regs(16'h3000, 16'h5A5A);
        ram_mode = 1'b0; man_ready = 1'b0;
        mio_en = 1'b1; r_w = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mar, mdr, r, mem_cs, err} !== 35'h0) begin
            errors++; $display("FAIL reset_mid_async got=%h exp=0", {mar, mdr, r, mem_cs, err});
        end
        mio_en = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        r_n = 0; cs_n = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (r) r_n++;
            if (mem_cs) cs_n++;
        end
        checks++; if (r_n !== 0 || cs_n !== 0) begin errors++; $display("FAIL reset_mid_no_r got=%0d/%0d exp=0/0", r_n, cs_n); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_simultaneous();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
